// File: rtl/mul_stage_pkg.sv
// Shared types for the multiplier result stage: buffer states, the
// per-entry payload layout and the NZCV bit positions.
package mul_stage_pkg;

    // Widths of the payload fields; must match the top-level N and RD_W.
    localparam int unsigned RESULT_W = 32;
    localparam int unsigned RD_TAG_W = 4;

    // Bit positions inside a 4-bit {N,Z,C,V} flag vector.
    localparam int unsigned N_BIT = 3;
    localparam int unsigned Z_BIT = 2;
    localparam int unsigned C_BIT = 1;
    localparam int unsigned V_BIT = 0;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_t;

    typedef struct packed {
        logic [RESULT_W-1:0] result;
        logic [RD_TAG_W-1:0] rd;
        logic [3:0]          nzcv;
        logic                set_flags;
    } mul_entry_t;

endpackage

// File: rtl/mul_skid_buffer.sv
// Generic 2-entry skid buffer over mul_entry_t. in_ready and out_valid are
// registered from the next state, so neither handshake side sees a
// combinational path from the other.
module mul_skid_buffer
    import mul_stage_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       flush,
    input  logic       in_valid,
    output logic       in_ready,
    input  mul_entry_t in_data,
    output logic       out_valid,
    input  logic       out_ready,
    output mul_entry_t out_data
);

    state_t     state;
    state_t     state_next;
    mul_entry_t main_q;
    mul_entry_t skid_q;
    logic       accept;
    logic       consume;
    logic       load_main_in;
    logic       load_main_skid;
    logic       load_skid_in;

    assign accept   = in_valid && in_ready;
    assign consume  = out_valid && out_ready;
    assign out_data = main_q;

    // State register plus registered handshake outputs derived from next state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= EMPTY;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
        end else begin
            state     <= state_next;
            in_ready  <= (state_next != TWO);
            out_valid <= (state_next != EMPTY);
        end
    end

    // Next-state and payload-move decode; flush overrides everything and
    // suppresses loads so a same-cycle accept is dropped.
    always_comb begin
        state_next     = state;
        load_main_in   = 1'b0;
        load_main_skid = 1'b0;
        load_skid_in   = 1'b0;
        unique case (state)
            EMPTY: begin
                if (accept) begin
                    state_next   = ONE;
                    load_main_in = 1'b1;
                end
            end
            ONE: begin
                if (accept && !consume) begin
                    state_next   = TWO;
                    load_skid_in = 1'b1;
                end else if (accept && consume) begin
                    load_main_in = 1'b1;
                end else if (consume) begin
                    state_next = EMPTY;
                end
            end
            TWO: begin
                if (consume) begin
                    state_next     = ONE;
                    load_main_skid = 1'b1;
                end
            end
            default: state_next = EMPTY;
        endcase
        if (flush) begin
            state_next     = EMPTY;
            load_main_in   = 1'b0;
            load_main_skid = 1'b0;
            load_skid_in   = 1'b0;
        end
    end

    // Payload registers; they change only on an accept or a skid-to-main shift.
    always_ff @(posedge clk) begin
        if (rst) begin
            main_q <= '0;
            skid_q <= '0;
        end else begin
            if (load_main_in) begin
                main_q <= in_data;
            end else if (load_main_skid) begin
                main_q <= skid_q;
            end
            if (load_skid_in) begin
                skid_q <= in_data;
            end
        end
    end

endmodule

// File: rtl/mul_result_stage.sv
// Registered result stage behind the scalar multiplier: packs result, tag and
// flags into the skid buffer and owns the architectural NZCV register.
// Optional feature macro: MUL_STICKY_OVF_EN (sticky status V, clr_sticky).
module mul_result_stage
    import mul_stage_pkg::*;
#(
    parameter int unsigned N    = 32,
    parameter int unsigned RD_W = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [N-1:0]    in_result,
    input  logic            in_z,
    input  logic            in_n,
    input  logic            in_c,
    input  logic            in_v,
    input  logic [RD_W-1:0] in_rd,
    input  logic            in_set_flags,
    input  logic            flush,
    input  logic            clr_sticky,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [N-1:0]    out_result,
    output logic [RD_W-1:0] out_rd,
    output logic [3:0]      out_nzcv,
    output logic            out_set_flags,
    output logic [3:0]      status_nzcv
);

    mul_entry_t in_entry;
    mul_entry_t head;
    logic       consume;
    logic [3:0] status_next;

    assign in_entry.result    = in_result;
    assign in_entry.rd        = in_rd;
    assign in_entry.nzcv      = {in_n, in_z, in_c, in_v};
    assign in_entry.set_flags = in_set_flags;

    mul_skid_buffer u_buf (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_entry),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (head)
    );

    assign out_result    = head.result;
    assign out_rd        = head.rd;
    assign out_nzcv      = head.nzcv;
    assign out_set_flags = head.set_flags;

    // A consume completes even during flush, so its flag update still lands.
    assign consume = out_valid && out_ready;

    // Next architectural flags from the head entry being consumed.
    always_comb begin
        status_next = status_nzcv;
        if (consume && head.set_flags) begin
            status_next = head.nzcv;
        end
`ifdef MUL_STICKY_OVF_EN
        if (consume && head.set_flags) begin
            status_next[V_BIT] = status_nzcv[V_BIT] | head.nzcv[V_BIT];
        end
        if (clr_sticky) begin
            status_next[V_BIT] = 1'b0;
        end
`endif
    end

`ifndef MUL_STICKY_OVF_EN
    logic unused_clr_sticky;
    assign unused_clr_sticky = clr_sticky;
`endif

    // Architectural NZCV register.
    always_ff @(posedge clk) begin
        if (rst) begin
            status_nzcv <= '0;
        end else begin
            status_nzcv <= status_next;
        end
    end

endmodule

// File: tb/tb_mul_result_stage.sv
// Directed self-checking bench for mul_result_stage. Build with
// +define+MUL_STICKY_OVF_EN to exercise the sticky-V expectations.
module tb_mul_result_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_result;
    logic        in_z, in_n, in_c, in_v;
    logic [3:0]  in_rd;
    logic        in_set_flags;
    logic        flush;
    logic        clr_sticky;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_result;
    logic [3:0]  out_rd;
    logic [3:0]  out_nzcv;
    logic        out_set_flags;
    logic [3:0]  status_nzcv;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    mul_result_stage #(.N(32), .RD_W(4)) dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_result    (in_result),
        .in_z         (in_z),
        .in_n         (in_n),
        .in_c         (in_c),
        .in_v         (in_v),
        .in_rd        (in_rd),
        .in_set_flags (in_set_flags),
        .flush        (flush),
        .clr_sticky   (clr_sticky),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_result   (out_result),
        .out_rd       (out_rd),
        .out_nzcv     (out_nzcv),
        .out_set_flags(out_set_flags),
        .status_nzcv  (status_nzcv)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [31:0] r, input logic [3:0] nzcv, input logic sf);
        in_valid     = 1'b1;
        in_result    = r;
        {in_n, in_z, in_c, in_v} = nzcv;
        in_set_flags = sf;
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_result = '0; in_rd = '0;
        {in_n, in_z, in_c, in_v} = 4'b0000; in_set_flags = 1'b0;
        flush = 1'b0; clr_sticky = 1'b0; out_ready = 1'b0;
        step(); step();
        rst = 1'b0;

        // Reset state
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_status", 32'(status_nzcv), 32'd0);
        chk("rst_result", out_result, 32'd0);

        // Single pass
        out_ready = 1'b1; in_rd = 4'd3;
        push(32'h6, 4'b0000, 1'b1);
        step();
        in_valid = 1'b0;
        chk("single_valid", 32'(out_valid), 32'd1);
        chk("single_result", out_result, 32'h6);
        chk("single_rd", 32'(out_rd), 32'd3);
        chk("single_sf", 32'(out_set_flags), 32'd1);
        step();
        chk("single_status", 32'(status_nzcv), 32'd0);
        chk("single_drain", 32'(out_valid), 32'd0);

        // Backpressure
        out_ready = 1'b0; in_rd = 4'd1;
        push(32'h11, 4'b0000, 1'b0);
        step();
        chk("bp_rdy1", 32'(in_ready), 32'd1);
        chk("bp_head1", out_result, 32'h11);
        push(32'h22, 4'b0000, 1'b0);
        step();
        chk("bp_rdy2", 32'(in_ready), 32'd0);
        chk("bp_head2", out_result, 32'h11);
        push(32'h33, 4'b0000, 1'b0);
        step();
        chk("bp_hold_rdy", 32'(in_ready), 32'd0);
        chk("bp_hold_head", out_result, 32'h11);
        out_ready = 1'b1;
        step();
        chk("bp_out2", out_result, 32'h22);
        chk("bp_out2_valid", 32'(out_valid), 32'd1);
        chk("bp_rdy_back", 32'(in_ready), 32'd1);
        step();
        in_valid = 1'b0;
        chk("bp_out3", out_result, 32'h33);
        chk("bp_out3_valid", 32'(out_valid), 32'd1);
        step();
        chk("bp_drain", 32'(out_valid), 32'd0);

        // Streaming
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            push(32'h100 + 32'(i), 4'b0000, 1'b0);
            step();
            chk("stream_valid", 32'(out_valid), 32'd1);
            chk("stream_data", out_result, 32'h100 + 32'(i));
            chk("stream_rdy", 32'(in_ready), 32'd1);
        end
        in_valid = 1'b0;
        step();
        chk("stream_drain", 32'(out_valid), 32'd0);

        // Flag write
        push(32'h0, 4'b0100, 1'b1);
        step();
        push(32'h8000_0000, 4'b1000, 1'b0);
        step();
        in_valid = 1'b0;
        chk("flag_status1", 32'(status_nzcv), 32'h4);
        chk("flag_head_nzcv", 32'(out_nzcv), 32'h8);
        chk("flag_head_sf", 32'(out_set_flags), 32'd0);
        step();
        chk("flag_status2", 32'(status_nzcv), 32'h4);
        chk("flag_drain", 32'(out_valid), 32'd0);

        // Flush from TWO with consume and in_valid in the flush cycle
        out_ready = 1'b0;
        push(32'hA1, 4'b0010, 1'b1);
        step();
        push(32'hA2, 4'b0000, 1'b0);
        step();
        chk("fl_two", 32'(in_ready), 32'd0);
        push(32'hA3, 4'b0000, 1'b0);
        flush = 1'b1; out_ready = 1'b1;
        step();
        flush = 1'b0; in_valid = 1'b0;
        chk("fl_valid", 32'(out_valid), 32'd0);
        chk("fl_rdy", 32'(in_ready), 32'd1);
        chk("fl_status", 32'(status_nzcv), 32'h2);
        step();
        chk("fl_valid2", 32'(out_valid), 32'd0);

        // Flush from ONE drops a same-cycle accept
        out_ready = 1'b0;
        push(32'hB1, 4'b0000, 1'b0);
        step();
        push(32'hB2, 4'b0000, 1'b0);
        flush = 1'b1;
        step();
        flush = 1'b0; in_valid = 1'b0;
        chk("fl1_valid", 32'(out_valid), 32'd0);
        step();
        chk("fl1_valid2", 32'(out_valid), 32'd0);

        // Reset mid-transfer beats flush and the pending flag consume
        push(32'hC1, 4'b1111, 1'b1);
        step();
        push(32'hC2, 4'b1111, 1'b1);
        step();
        rst = 1'b1; flush = 1'b1; out_ready = 1'b1;
        push(32'hC3, 4'b0000, 1'b0);
        step();
        rst = 1'b0; flush = 1'b0; in_valid = 1'b0;
        chk("rst2_valid", 32'(out_valid), 32'd0);
        chk("rst2_rdy", 32'(in_ready), 32'd1);
        chk("rst2_status", 32'(status_nzcv), 32'd0);
        chk("rst2_payload", out_result, 32'd0);

        // Sticky V behaviour
        out_ready = 1'b1;
        push(32'h1, 4'b0001, 1'b1);
        step();
        push(32'h2, 4'b0000, 1'b1);
        step();
        in_valid = 1'b0;
        chk("v_first", 32'(status_nzcv), 32'h1);
        step();
`ifdef MUL_STICKY_OVF_EN
        chk("v_sticky", 32'(status_nzcv), 32'h1);
`else
        chk("v_plain", 32'(status_nzcv), 32'h0);
`endif
        clr_sticky = 1'b1;
        step();
        clr_sticky = 1'b0;
        chk("v_clr", 32'(status_nzcv), 32'h0);
        push(32'h3, 4'b0001, 1'b1);
        step();
        in_valid = 1'b0; clr_sticky = 1'b1;
        step();
        clr_sticky = 1'b0;
`ifdef MUL_STICKY_OVF_EN
        chk("v_clr_prio", 32'(status_nzcv), 32'h0);
`else
        chk("v_clr_ignored", 32'(status_nzcv), 32'h1);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
